// File: rtl/ethernet_frame_builder.sv
// Ethernet TX frame builder: serialises a 14-byte header, forwards the payload
// and zero-pads short frames up to MIN_FRAME_LEN bytes. No FCS is generated.
module ethernet_frame_builder #(
  parameter int DATA_WIDTH    = 8,
  parameter int MIN_FRAME_LEN = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_hdr_valid,
  output logic                  s_hdr_ready,
  input  logic [47:0]           s_hdr_dst_mac,
  input  logic [47:0]           s_hdr_src_mac,
  input  logic [15:0]           s_hdr_ethertype,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} state_t;

  state_t                  state_q, state_d;
  logic [111:0]            hdr_q, hdr_d;
  logic [10:0]             byte_cnt_q, byte_cnt_d;
  logic                    err_q, err_d;
  logic                    hdr_rdy_q, hdr_rdy_d;
  logic                    busy_q, busy_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;
  logic                    m_tuser_q, m_tuser_d;

  logic load_en, hdr_hs, out_hs, pay_rdy, pay_hs;

  // Byte counter saturates at 2047; saturation only ever suppresses padding.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  // True when the byte about to load brings the frame to the minimum length.
  function automatic logic reaches_min(input logic [10:0] v);
    return ({1'b0, v} + 12'd1) >= 12'(MIN_FRAME_LEN);
  endfunction

  assign s_hdr_ready   = hdr_rdy_q;
  assign s_axis_tready = pay_rdy;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign busy          = busy_q;
  assign frame_count   = frame_cnt_q;

  // Next-state, output-register load and bookkeeping for the frame FSM.
  always_comb begin
    load_en = !m_tvalid_q || m_axis_tready;
    hdr_hs  = s_hdr_valid && hdr_rdy_q;
    out_hs  = m_tvalid_q && m_axis_tready;
    pay_rdy = (state_q == PAYLOAD) && load_en;
    pay_hs  = s_axis_tvalid && pay_rdy;

    state_d     = state_q;
    hdr_d       = hdr_q;
    byte_cnt_d  = byte_cnt_q;
    err_d       = err_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tuser_d   = m_tuser_q;

    // A free output register empties unless a state below refills it.
    if (load_en) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
      m_tuser_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (hdr_hs) begin
          hdr_d      = {s_hdr_dst_mac, s_hdr_src_mac, s_hdr_ethertype};
          byte_cnt_d = 11'd0;
          err_d      = 1'b0;
          state_d    = HEADER;
        end
      end
      HEADER: begin
        if (load_en) begin
          m_tdata_d  = hdr_q[111:104];
          m_tvalid_d = 1'b1;
          hdr_d      = {hdr_q[103:0], 8'h00};
          byte_cnt_d = sat_inc(byte_cnt_q);
          if (byte_cnt_q == 11'd13) state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pay_hs) begin
          m_tdata_d  = s_axis_tdata;
          m_tvalid_d = 1'b1;
          byte_cnt_d = sat_inc(byte_cnt_q);
          err_d      = err_q | s_axis_tuser;
          if (s_axis_tlast) begin
            if (reaches_min(byte_cnt_q)) begin
              m_tlast_d = 1'b1;
              m_tuser_d = err_q | s_axis_tuser;
              state_d   = IDLE;
            end else begin
              state_d   = PAD;
            end
          end
        end
      end
      PAD: begin
        if (load_en) begin
          m_tdata_d  = '0;
          m_tvalid_d = 1'b1;
          byte_cnt_d = sat_inc(byte_cnt_q);
          if (reaches_min(byte_cnt_q)) begin
            m_tlast_d = 1'b1;
            m_tuser_d = err_q;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new header accepted in the same cycle as the previous tlast handshake keeps busy high.
    if (hdr_hs)                  busy_d = 1'b1;
    else if (out_hs && m_tlast_q) busy_d = 1'b0;

    if (out_hs && m_tlast_q) frame_cnt_d = frame_cnt_q + 16'd1;

    // Header ready follows IDLE one cycle late, giving a one-cycle gap between frames.
    hdr_rdy_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any frame in flight without tlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
      hdr_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
      hdr_rdy_q   <= hdr_rdy_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tuser_q   <= m_tuser_d;
    end
  end

endmodule

// File: doc/ethernet_frame_builder.md
Name: ethernet_frame_builder

Overview:
TX-direction counterpart to the RX frame parser. Accepts per-frame header metadata (destination MAC, source MAC, EtherType) and a byte-wide payload AXI-Stream. Emits a complete Ethernet frame (14-byte header, payload, zero padding to the minimum length, no FCS) on an AXI-Stream master. That master feeds the 1G RGMII MAC wrapper TX port, and the MAC appends preamble and FCS.

Parameters:
DATA_WIDTH, 8, stream width in bits; only 8 is supported.
MIN_FRAME_LEN, 60, minimum output length in bytes, excluding FCS; shorter frames are zero-padded.

Ports:
clk  input  1  system clock, 125 MHz
rst_n  input  1  asynchronous active-low reset
s_hdr_valid  input  1  header metadata valid
s_hdr_ready  output  1  header accepted when valid && ready
s_hdr_dst_mac  input  48  destination MAC, [47:40] is sent first
s_hdr_src_mac  input  48  source MAC, [47:40] is sent first
s_hdr_ethertype  input  16  EtherType, [15:8] is sent first
s_axis_tdata  input  8  payload byte
s_axis_tvalid  input  1  payload valid
s_axis_tready  output  1  payload ready
s_axis_tlast  input  1  last payload byte
s_axis_tuser  input  1  payload error flag
m_axis_tdata  output  8  frame byte to MAC
m_axis_tvalid  output  1  frame byte valid
m_axis_tready  input  1  MAC ready
m_axis_tlast  output  1  last frame byte
m_axis_tuser  output  1  frame-bad flag; valid only with tlast
busy  output  1  high from header accept until the last byte is accepted
frame_count  output  16  completed frames, wraps at 0xFFFF

Behaviour:
- One clock domain (clk), async active-low reset (rst_n). Reset clears all outputs to 0, frame_count to 0, and the FSM to IDLE.
- Reset asserted mid-frame: the output stream is truncated immediately, with no tlast. The MAC handles the aborted frame.
- Output stage: a single register. The register loads only when !m_axis_tvalid || m_axis_tready. tdata, tlast and tuser hold stable while tvalid && !tready.
- FSM states: IDLE, HEADER, PAYLOAD, PAD.
- IDLE:
  - s_hdr_ready=1, all other readies 0.
  - On a header handshake: latch the 112 header bits into a shift register, clear byte_cnt (11 bits) and the err_sticky flag, go to HEADER.
- HEADER:
  - Emits 14 bytes in order: dst[47:40] … dst[7:0], src[47:40] … src[7:0], type[15:8], type[7:0].
  - Byte 0 appears on m_axis the cycle after the header handshake.
  - After the 14th byte loads, go to PAYLOAD.
  - s_axis_tready=0 in this state.
- PAYLOAD:
  - s_axis_tready = (!m_axis_tvalid || m_axis_tready). The payload passes straight into the output register with zero bubbles.
  - byte_cnt increments per loaded byte and saturates at 2047.
  - err_sticky |= s_axis_tuser on each payload beat.
  - On the s_axis_tlast beat:
    - If byte_cnt+1 >= MIN_FRAME_LEN: that byte is the frame's last byte; output tlast=1 and tuser=err_sticky|s_axis_tuser, then go to IDLE.
    - Otherwise: tlast=0 and go to PAD.
  - The payload is always ≥1 byte. A zero-length payload is not representable.
- PAD:
  - Emits 0x00 bytes until byte_cnt reaches MIN_FRAME_LEN.
  - The final pad byte carries tlast=1 and tuser=err_sticky.
  - Go to IDLE.
- The FSM returns to IDLE when the final byte loads into the output register.
  - s_hdr_ready is asserted in the following cycle, so back-to-back frames have a 1-cycle gap on m_axis.
- busy clears and frame_count increments when the tlast beat handshakes on m_axis, not when it loads.
- A header presented while not IDLE is held off by s_hdr_ready=0, with no loss.
- There is no maximum-length check. Oversize payloads pass through; byte_cnt saturates, and saturation has no effect other than suppressing padding.
- m_axis_tready is honoured in every state. Backpressure stalls header, payload and pad emission equally.

Test Plan:
- Header dst=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, type=0x0800, payload 46 bytes 0x00..0x2D, m_axis_tready=1 -> 60 bytes out. Bytes 0–5 are FF, 6–11 are 02 00 00 00 00 01, 12–13 are 08 00. Bytes 14–59 are the payload. tlast on byte 59, tuser=0, no pad bytes, frame_count=1.
- Same header with a 4-byte payload AA BB CC DD -> bytes 14–17 are AA BB CC DD, bytes 18–59 are 0x00, tlast only on byte 59, total 60 beats.
- 100-byte payload with s_axis_tuser=1 on byte 50 only -> 114 bytes out, tlast on byte 113, tuser=1 on that beat.
- Random m_axis_tready at 30% duty with a 64-byte payload -> output bytes identical to the tready=1 run. tdata stable during every stall, no beat duplicated or dropped.
- Two frames back-to-back with the second header valid the whole time -> second header accepted the cycle after the first frame's last byte loads. frame_count=2, busy low only after the second tlast handshake.
- Assert rst_n=0 at output byte 20 of a frame -> m_axis_tvalid=0, busy=0, frame_count=0 immediately. After release, a new frame is emitted correctly from byte 0.
